// File: rtl/vga_pkg.sv
// Shared VGA mode constants, axis-total helper and colour-width constants
// used by vga_timing_gen and its delay line.
package vga_pkg;

  localparam int RGB_CHANNELS = 3;
  localparam int BAR_COUNT    = 8;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int rgb_width(input int color_bits);
    return RGB_CHANNELS * color_bits;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width/depth parametrised shift register with synchronous clear and
// advance enable; degenerates to a wire when DEPTH is 0.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      // Clear wins over enable so a reset while paused still empties the line.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= '0;
          end
        end else if (en) begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator and pixel output stage.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int COLOR_BITS = 1,
  parameter int PIPE_LAT   = 1,
  parameter int COORD_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [COORD_W-1:0]      pixel_col,
  output logic [COORD_W-1:0]      pixel_row,
  output logic                    pixel_valid,
  output logic                    line_start,
  output logic                    frame_start,
  input  logic [3*COLOR_BITS-1:0] pixel_rgb,
  output logic                    hsync,
  output logic                    vsync,
  output logic [3*COLOR_BITS-1:0] rgb
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic                    test_mode
`endif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int RGB_W   = rgb_width(COLOR_BITS);

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACTIVE = (HSYNC_POL != 0);
  localparam logic VS_ACTIVE = (VSYNC_POL != 0);

  generate
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_coord_w
      $error("vga_timing_gen: COORD_W too narrow for the frame totals");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_pipe_lat
      $error("vga_timing_gen: PIPE_LAT must be 0..15");
    end
  endgenerate

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;

  // v_cnt only moves on the h_cnt wrap, so vsync edges land on line boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + COORD_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  logic hs_raw;
  logic vs_raw;

  assign pixel_col   = h_cnt;
  assign pixel_row   = v_cnt;
  assign pixel_valid = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw      = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw      = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign line_start  = en && !rst && (h_cnt == '0) && (v_cnt < V_ACT);
  assign frame_start = en && !rst && (h_cnt == '0) && (v_cnt == '0);

  logic hs_d;
  logic vs_d;
  logic valid_d;

  // Timing flags travel alongside the pixel logic so they meet its colour.
  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_LAT)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  ({hs_raw, vs_raw, pixel_valid}),
    .dout ({hs_d, vs_d, valid_d})
  );

  logic [RGB_W-1:0] color_sel;

`ifdef VGA_TEST_PATTERN_EN
  logic [COORD_W-1:0] col_d;
  logic [COORD_W+2:0] col_x8;
  logic [2:0]         bar_idx;
  logic [RGB_W-1:0]   bar_rgb;

  vga_delay_line #(
    .WIDTH (COORD_W),
    .DEPTH (PIPE_LAT)
  ) u_col_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (h_cnt),
    .dout (col_d)
  );

  // Only active columns reach rgb, and those always map to 0..BAR_COUNT-1.
  assign col_x8    = {col_d, 3'b000};
  assign bar_idx   = 3'(col_x8 / (COORD_W+3)'(H_ACTIVE));
  assign bar_rgb   = {{COLOR_BITS{bar_idx[2]}},
                      {COLOR_BITS{bar_idx[1]}},
                      {COLOR_BITS{bar_idx[0]}}};
  assign color_sel = test_mode ? bar_rgb : pixel_rgb;
`else
  assign color_sel = pixel_rgb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= ~HS_ACTIVE;
      vsync <= ~VS_ACTIVE;
    end else if (en) begin
      rgb   <= valid_d ? color_sel : '0;
      hsync <= hs_d ~^ HS_ACTIVE;
      vsync <= vs_d ~^ VS_ACTIVE;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny 15x8 frame with PIPE_LAT=2
// and active-low syncs; the bench models the pixel logic and expected outputs.
module tb_vga_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] pixel_rgb = 3'b000;
  logic [9:0] pixel_col;
  logic [9:0] pixel_row;
  logic       pixel_valid;
  logic       line_start;
  logic       frame_start;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  int   m_h, m_v;
  int   c1_h, c1_v, c2_h, c2_v;
  bit   c1_ok, c2_ok;
  bit   tp_on;
  logic [2:0] exp_rgb;
  logic exp_hs, exp_vs;
  int   fs_seen, ls_seen, hs_low, vs_low;

  vga_timing_gen #(
    .H_ACTIVE   (8),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (2),
    .V_ACTIVE   (4),
    .V_FP       (1),
    .V_SYNC     (2),
    .V_BP       (1),
    .HSYNC_POL  (0),
    .VSYNC_POL  (0),
    .COLOR_BITS (1),
    .PIPE_LAT   (2),
    .COORD_W    (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .pixel_col   (pixel_col),
    .pixel_row   (pixel_row),
    .pixel_valid (pixel_valid),
    .line_start  (line_start),
    .frame_start (frame_start),
    .pixel_rgb   (pixel_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .test_mode   (test_mode)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit in_hs(input int h);
    return (h >= 10) && (h < 13);
  endfunction

  function automatic bit in_vs(input int v);
    return (v >= 5) && (v < 7);
  endfunction

  function automatic bit is_active(input int h, input int v);
    return (h < 8) && (v < 4);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got,
                              input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, want, $time);
    end
  endtask

  // One pixel clock: drive, check coordinates/pulses, clock, check output stage.
  task automatic apply_stimulus(input logic en_v);
    en = en_v;
    if (!en_v)          pixel_rgb = 3'b110;
    else if (!c2_ok)    pixel_rgb = 3'b111;
    else if (tp_on)     pixel_rgb = ~3'(c2_h);
    else                pixel_rgb = 3'(c2_h);
    #1;
    check_output("pixel_col", pixel_col, m_h);
    check_output("pixel_row", pixel_row, m_v);
    check_output("pixel_valid", pixel_valid, is_active(m_h, m_v));
    check_output("line_start", line_start, en_v && m_h == 0 && m_v < 4);
    check_output("frame_start", frame_start, en_v && m_h == 0 && m_v == 0);
    if (frame_start) fs_seen++;
    if (line_start)  ls_seen++;
    @(posedge clk);
    #1;
    if (en_v) begin
      exp_rgb = (c2_ok && is_active(c2_h, c2_v)) ? 3'(c2_h) : 3'b000;
      exp_hs  = !(c2_ok && in_hs(c2_h));
      exp_vs  = !(c2_ok && in_vs(c2_v));
      c2_h = c1_h; c2_v = c1_v; c2_ok = c1_ok;
      c1_h = m_h;  c1_v = m_v;  c1_ok = 1'b1;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
    check_output("rgb", rgb, exp_rgb);
    check_output("hsync", hsync, exp_hs);
    check_output("vsync", vsync, exp_vs);
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en  = 1'b1;
    pixel_rgb = 3'b111;
    #1;
    check_output("rst_line_start", line_start, 0);
    check_output("rst_frame_start", frame_start, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_h = 0; m_v = 0;
    c1_ok = 1'b0; c2_ok = 1'b0;
    exp_rgb = 3'b000; exp_hs = 1'b1; exp_vs = 1'b1;
    check_output("rst_col", pixel_col, 0);
    check_output("rst_row", pixel_row, 0);
    check_output("rst_valid", pixel_valid, 1);
    check_output("rst_rgb", rgb, 0);
    check_output("rst_hsync", hsync, 1);
    check_output("rst_vsync", vsync, 1);
  endtask

  initial begin
    tp_on = 1'b0;
    c1_h = 0; c1_v = 0; c2_h = 0; c2_v = 0;
    fs_seen = 0; ls_seen = 0; hs_low = 0; vs_low = 0;
    @(posedge clk);
    #1;
    apply_reset();

    // First frame: one frame_start, four line_starts.
    fs_seen = 0; ls_seen = 0;
    repeat (120) apply_stimulus(1'b1);
    check_output("frame1_fs_count", fs_seen, 1);
    check_output("frame1_ls_count", ls_seen, 4);

    // Second frame: frame_start again at cycle 120, sync widths over one period.
    fs_seen = 0; hs_low = 0; vs_low = 0;
    repeat (120) apply_stimulus(1'b1);
    check_output("frame2_fs_count", fs_seen, 1);
    check_output("hsync_low_clocks", hs_low, 24);
    check_output("vsync_low_clocks", vs_low, 30);

    // Pause mid-line at col 4 of row 1.
    for (int i = 0; i < 200 && !(m_h == 4 && m_v == 1); i++) apply_stimulus(1'b1);
    check_output("reach_col4", m_h, 4);
    repeat (5) apply_stimulus(1'b0);
    check_output("freeze_col", pixel_col, 4);
    check_output("freeze_row", pixel_row, 1);
    repeat (30) apply_stimulus(1'b1);

    // Pause exactly on a frame start: pulses must stay low while paused.
    for (int i = 0; i < 200 && !(m_h == 0 && m_v == 0); i++) apply_stimulus(1'b1);
    fs_seen = 0;
    repeat (2) apply_stimulus(1'b0);
    check_output("paused_fs_count", fs_seen, 0);
    repeat (20) apply_stimulus(1'b1);
    check_output("resumed_fs_count", fs_seen, 1);

    // Reset in the middle of a vsync/hsync region.
    for (int i = 0; i < 200 && !(m_h == 11 && m_v == 5); i++) apply_stimulus(1'b1);
    check_output("reach_r5c11", m_v * 100 + m_h, 511);
    apply_reset();
    hs_low = 0; vs_low = 0;
    repeat (10) apply_stimulus(1'b1);
    check_output("post_rst_hs_low", hs_low, 0);
    check_output("post_rst_vs_low", vs_low, 0);
    repeat (60) apply_stimulus(1'b1);

`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    tp_on = 1'b1;
    repeat (120) apply_stimulus(1'b1);
    test_mode = 1'b0;
    tp_on = 1'b0;
    repeat (10) apply_stimulus(1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
